// File: rtl/replay_pkg.sv
// Shared types for the trace replay sequencer: record layout, FSM states, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package replay_pkg;

    localparam int CYCLE_W_DEF = 48;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 64;
    localparam int DEPTH_DEF   = 4;

    // Sequencer states. DONE and ERR are only left through reset.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1,
        ST_ERR  = 2'd2
    } seq_state_t;

    // One trace record at the default widths. Parameterised instances build
    // a record of the same field order with their own widths.
    typedef struct packed {
        logic [CYCLE_W_DEF-1:0] cycle;
        logic [ADDR_W_DEF-1:0]  addr;
        logic [DATA_W_DEF-1:0]  data;
        logic                   last;
    } rec_t;

endpackage

// File: rtl/replay_rec_fifo.sv
// Record buffer: DEPTH-entry synchronous FIFO with first-word fall-through head.
// Latency: a pushed word is visible at o_head_dat one clock after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; the caller gates on o_full/o_empty.
//
// Ports: clock/reset (sync, active-low), i_push/i_push_dat write side,
//        i_pop consumes the head, o_head_dat current head, o_full/o_empty flags.
module replay_rec_fifo
    import replay_pkg::*;
#(
    parameter int WIDTH = $bits(rec_t),
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/replay_poke_sequencer.sv
// Replays a timestamped poke trace: applies each record when the target cycle counter equals its timestamp.
// Latency: poke pulse one clock after the head record is popped; counter advances at most one per clock.
// Backpressure: in_ready drops when the buffer is full, after the last record is accepted, or outside RUN.
//
// Ports: clock/reset (sync, active-low); in_* record input with valid/ready;
//        stall freezes target time; poke_* registered one-cycle apply pulse;
//        cycle current target time; starved/done/error status.
module replay_poke_sequencer
    import replay_pkg::*;
#(
    parameter int CYCLE_W = CYCLE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CYCLE_W-1:0] in_cycle,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    input  logic               stall,
    output logic               poke_valid,
    output logic [ADDR_W-1:0]  poke_addr,
    output logic [DATA_W-1:0]  poke_data,
    output logic [CYCLE_W-1:0] cycle,
    output logic               starved,
    output logic               done,
    output logic               error
);

    typedef struct packed {
        logic [CYCLE_W-1:0] cycle;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
        logic               last;
    } seq_rec_t;

    seq_state_t         r_state;
    logic               r_last_acc;
    logic [CYCLE_W-1:0] r_cycle;
    logic               r_poke_vld;
    logic [ADDR_W-1:0]  r_poke_addr;
    logic [DATA_W-1:0]  r_poke_data;
    logic               r_done;
    logic               r_error;

    seq_rec_t           w_in_rec;
    seq_rec_t           w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_is_run;
    logic               w_push;
    logic               w_pop;
    logic               w_match;
    logic               w_ahead;
    logic               w_behind;

    assign w_in_rec = {in_cycle, in_addr, in_data, in_last};
    assign w_is_run = (r_state == ST_RUN);
    assign in_ready = w_is_run && !w_full && !r_last_acc;
    assign w_push   = in_valid && in_ready;

    // Unsigned compare of the head timestamp against target time; the three
    // outcomes are mutually exclusive and all require a head to be present.
    assign w_match  = !w_empty && (w_head.cycle == r_cycle);
    assign w_ahead  = !w_empty && (w_head.cycle >  r_cycle);
    assign w_behind = !w_empty && (w_head.cycle <  r_cycle);
    assign w_pop    = w_is_run && !stall && w_match;

    replay_rec_fifo #(
        .WIDTH ($bits(seq_rec_t)),
        .DEPTH (DEPTH)
    ) u_rec_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_in_rec),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_last_acc  <= 1'b0;
            r_cycle     <= '0;
            r_poke_vld  <= 1'b0;
            r_poke_addr <= '0;
            r_poke_data <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_poke_vld <= 1'b0;
            if (w_push && in_last) r_last_acc <= 1'b1;
            case (r_state)
                ST_RUN: begin
                    // A head older than target time can never be applied;
                    // this is checked even while stalled.
                    if (w_behind) begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                    end else if (!stall) begin
                        if (w_match) begin
                            r_poke_vld  <= 1'b1;
                            r_poke_addr <= w_head.addr;
                            r_poke_data <= w_head.data;
                            if (w_head.last) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end else if (w_ahead) begin
                            // Time only advances toward a buffered record,
                            // so an empty buffer holds the counter.
                            r_cycle <= r_cycle + CYCLE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign poke_valid = r_poke_vld;
    assign poke_addr  = r_poke_addr;
    assign poke_data  = r_poke_data;
    assign cycle      = r_cycle;
    assign done       = r_done;
    assign error      = r_error;
    assign starved    = w_is_run && w_empty && !r_last_acc;

endmodule
